wb_fw_interface: RTL and testbench

Simulation-only Wishbone B3 slave that gives firmware running on the picorv32 a mailbox to the testbench. Firmware writes a trigger word and a test status; the bench watches `trigger_reg`. The block also exposes the SoC interrupt vector, a cycle counter and a fixed ID for read-back. It sits on the SoC bus matrix as the `fw_interface` slave and is instantiated only when `SIMULATION` is defined.

---
 rtl/fw_interface_pkg.sv | 42 ++++
 rtl/wb_fw_interface.sv | 139 +++++++++++++
 tb/tb_wb_fw_interface.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fw_interface_pkg.sv
// -----------------------------------------------------------------------------
// fw_interface_pkg
// Shared constants for the firmware mailbox slave (wb_fw_interface):
//   - register word offsets (wb_adr_i[4:2])
//   - default ID register value ("FWIF")
//   - STATUS pass/fail encodings written by firmware
//   - byte-lane write-merge helper
// -----------------------------------------------------------------------------
package fw_interface_pkg;

  // Word offsets decoded from wb_adr_i[4:2]
  localparam logic [2:0] OFF_TRIGGER = 3'd0;
  localparam logic [2:0] OFF_SCRATCH = 3'd1;
  localparam logic [2:0] OFF_IRQ     = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_CYCLES  = 3'd4;
  localparam logic [2:0] OFF_ID      = 3'd5;

  // Value returned by the ID register unless overridden
  localparam logic [31:0] FW_ID_DEFAULT = 32'h4657_4946;

  // STATUS encodings as written by firmware
  localparam logic [1:0] STATUS_PASS = 2'b01;
  localparam logic [1:0] STATUS_FAIL = 2'b10;

  // Merge new data into an old word, one byte lane per select bit
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] result;
    result = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        result[i*8 +: 8] = new_val[i*8 +: 8];
      end else begin
        result[i*8 +: 8] = old_val[i*8 +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_fw_interface.sv
// -----------------------------------------------------------------------------
// wb_fw_interface
// Wishbone B3 classic slave giving firmware a mailbox to the testbench.
//
// Ports:
//   wb_clk_i      clock, all logic on the rising edge
//   wb_rst_i      synchronous active-high reset
//   wb_adr_i      byte address, only [4:2] decoded
//   wb_dat_i      write data
//   wb_sel_i      write byte enables
//   wb_we_i       write strobe
//   wb_bte_i      unused
//   wb_cti_i      unused, every access treated as classic
//   wb_cyc_i      bus cycle valid
//   wb_stb_i      strobe
//   interrupts    SoC IRQ vector, registered every clock for read-back
//   wb_ack_o      normal termination (registered, one cycle)
//   wb_err_o      error termination for unmapped offsets 0x18/0x1C
//   wb_rty_o      constant 0
//   wb_dat_o      read data, non-zero only in an ack cycle
//   trigger_reg   TRIGGER register contents
//
// Register map: 0x00 TRIGGER RW, 0x04 SCRATCH RW, 0x08 IRQ RO,
//               0x0C STATUS RW[1:0], 0x10 CYCLES RO, 0x14 ID RO.
//
// Configuration macro FW_INTERFACE_CYCLE_COUNTER_EN: when defined the
// free-running CYCLES counter is built; otherwise 0x10 acks and reads 0.
// -----------------------------------------------------------------------------
module wb_fw_interface
  import fw_interface_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = FW_ID_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [31:0] interrupts,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] wb_dat_o,
  output logic [31:0] trigger_reg
);

  logic [31:0] scratch_r;
  logic [1:0]  status_r;
  logic [31:0] irq_r;
`ifdef FW_INTERFACE_CYCLE_COUNTER_EN
  logic [31:0] cycles_r;
`endif

  logic [2:0]  offset_s;
  logic        req_s;
  logic        unmapped_s;
  logic [31:0] rdata_s;
  logic [31:0] wdata_s;
  logic        unused_s;

  assign offset_s = wb_adr_i[4:2];

  // A pending termination blocks a new request, which yields the
  // two-clock minimum cycle when cyc/stb are held.
  assign req_s = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  assign wb_rty_o = 1'b0;

  assign unused_s = ^{wb_bte_i, wb_cti_i, wb_adr_i[31:5], wb_adr_i[1:0]};

  // Read mux and unmapped-offset decode from the current register values
  always_comb begin
    rdata_s    = 32'd0;
    unmapped_s = 1'b0;
    case (offset_s)
      OFF_TRIGGER: rdata_s = trigger_reg;
      OFF_SCRATCH: rdata_s = scratch_r;
      OFF_IRQ:     rdata_s = irq_r;
      OFF_STATUS:  rdata_s = {30'd0, status_r};
`ifdef FW_INTERFACE_CYCLE_COUNTER_EN
      OFF_CYCLES:  rdata_s = cycles_r;
`else
      OFF_CYCLES:  rdata_s = 32'd0;
`endif
      OFF_ID:      rdata_s = ID_VALUE;
      default:     unmapped_s = 1'b1;
    endcase
  end

  // Byte-merged write value; reusing rdata_s as the old value also gives
  // STATUS its zero upper bits.
  assign wdata_s = apply_sel(rdata_s, wb_dat_i, wb_sel_i);

  // Bus termination, read data and register file
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= 32'd0;
      trigger_reg <= 32'd0;
      scratch_r   <= 32'd0;
      status_r    <= 2'd0;
      irq_r       <= 32'd0;
`ifdef FW_INTERFACE_CYCLE_COUNTER_EN
      cycles_r    <= 32'd0;
`endif
    end else begin
      irq_r    <= interrupts;
`ifdef FW_INTERFACE_CYCLE_COUNTER_EN
      cycles_r <= cycles_r + 32'd1;
`endif
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
      if (req_s) begin
        if (unmapped_s) begin
          wb_err_o <= 1'b1;
        end else begin
          wb_ack_o <= 1'b1;
          wb_dat_o <= rdata_s;
          if (wb_we_i) begin
            case (offset_s)
              OFF_TRIGGER: trigger_reg <= wdata_s;
              OFF_SCRATCH: scratch_r   <= wdata_s;
              OFF_STATUS:  status_r    <= wdata_s[1:0];
              default:     ; // read-only targets discard the write
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_fw_interface.sv
// -----------------------------------------------------------------------------
// tb_wb_fw_interface
// Self-checking bench for wb_fw_interface: directed scenarios plus a
// randomized sweep against a register-level reference model.
// -----------------------------------------------------------------------------
module tb_wb_fw_interface;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic [1:0]  wb_bte_i;
  logic [2:0]  wb_cti_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] interrupts;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [31:0] wb_dat_o;
  logic [31:0] trigger_reg;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [31:0] m_trig;
  logic [31:0] m_scr;
  logic [1:0]  m_stat;
  time         t_rst;   // time of the last clock edge that saw reset high

  wb_fw_interface dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_bte_i   (wb_bte_i),
    .wb_cti_i   (wb_cti_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .interrupts (interrupts),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_rty_o   (wb_rty_o),
    .wb_dat_o   (wb_dat_o),
    .trigger_reg(trigger_reg)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // One classic access: request at the next edge, sample right after it.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd,
                     output logic ak, output logic er, output time tq);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = w;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk_i);
    tq = $time;
    #1;
    ak = wb_ack_o; er = wb_err_o; rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    t_rst = $time;
    #1;
    wb_rst_i = 1'b0;
    m_trig = 32'd0; m_scr = 32'd0; m_stat = 2'd0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ak, er; time tq;
    wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'd0; wb_we_i = 1'b0;
    wb_bte_i = 2'd0; wb_cti_i = 3'd0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    interrupts = 32'd0;
    do_reset();
    checks++;
    if ({wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o, trigger_reg} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b err=%b rty=%b dat=%h trig=%h, want all 0",
               wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o, trigger_reg);
    end
    bus(32'h14, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'h4657_4946) begin
      errors++;
      $display("FAIL id_read: ack=%b err=%b dat=%h, want ack=1 err=0 dat=46574946", ak, er, rd);
    end
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL id_ack_width: ack=%b dat=%h one cycle later, want 0/0", wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic ak, er; time tq;
    bus(32'h00, 1'b1, 32'hDEAD_BEEF, 4'b0101, rd, ak, er, tq);
    m_trig = merge(m_trig, 32'hDEAD_BEEF, 4'b0101);
    checks++;
    if (trigger_reg !== 32'h00AD_00EF || ak !== 1'b1) begin
      errors++;
      $display("FAIL byte_write: trig=%h ack=%b, want 00ad00ef ack=1", trigger_reg, ak);
    end
    bus(32'h00, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== 32'h00AD_00EF) begin
      errors++;
      $display("FAIL byte_readback: got %h want 00ad00ef", rd);
    end
    bus(32'h00, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, ak, er, tq);
    checks++;
    if (trigger_reg !== 32'h00AD_00EF || ak !== 1'b1) begin
      errors++;
      $display("FAIL sel_zero_write: trig=%h ack=%b, want 00ad00ef ack=1", trigger_reg, ak);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic ak, er; time tq;
    bus(32'h04, 1'b1, 32'h1234_5678, 4'hF, rd, ak, er, tq);
    m_scr = 32'h1234_5678;
    wb_adr_i = 32'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge wb_clk_i);
      #1;
      checks++;
      if (wb_ack_o !== k[0] || wb_dat_o !== (k[0] ? m_scr : 32'd0)) begin
        errors++;
        $display("FAIL hold_ack_cycle%0d: ack=%b dat=%h, want ack=%b", k, wb_ack_o, wb_dat_o, k[0]);
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic ak, er; time tq;
    interrupts = 32'h0000_0004;
    @(posedge wb_clk_i);
    #1;
    bus(32'h08, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== 32'h0000_0004 || ak !== 1'b1) begin
      errors++;
      $display("FAIL irq_read: got %h ack=%b want 00000004 ack=1", rd, ak);
    end
    bus(32'h08, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ak, er, tq);
    bus(32'h08, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== 32'h0000_0004) begin
      errors++;
      $display("FAIL irq_ro: got %h want 00000004", rd);
    end
  endtask

  task automatic test_unmapped_status();
    logic [31:0] rd; logic ak, er; time tq;
    bus(32'h18, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (er !== 1'b1 || ak !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read: err=%b ack=%b dat=%h, want err=1 ack=0 dat=0", er, ak, rd);
    end
    checks++;
    if (wb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_width: err=%b one cycle later, want 0", wb_err_o);
    end
    bus(32'h0C, 1'b1, 32'h0000_0007, 4'hF, rd, ak, er, tq);
    m_stat = 2'b11;
    bus(32'h0C, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== 32'h0000_0003) begin
      errors++;
      $display("FAIL status_mask: got %h want 00000003", rd);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] rd; logic ak, er; time tq;
    // strobe without cycle is not a request
    wb_adr_i = 32'h04; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_term: ack=%b err=%b want 0/0", wb_ack_o, wb_err_o);
    end
    bus(32'h04, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== m_scr) begin
      errors++;
      $display("FAIL cancel_nowrite: scratch=%h want %h", rd, m_scr);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic ak, er; time tq;
    bus(32'h04, 1'b1, 32'hA5A5_A5A5, 4'hF, rd, ak, er, tq);
    bus(32'h0C, 1'b1, 32'h0000_0002, 4'hF, rd, ak, er, tq);
    wb_adr_i = 32'h00; wb_dat_i = 32'h1357_9BDF; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    t_rst = $time;
    #1;
    wb_rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    m_trig = 32'd0; m_scr = 32'd0; m_stat = 2'd0;
    checks++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'd0 || trigger_reg !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_access: ack=%b err=%b dat=%h trig=%h want all 0",
               wb_ack_o, wb_err_o, wb_dat_o, trigger_reg);
    end
    bus(32'h04, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL rst_scratch: got %h want 0", rd);
    end
    bus(32'h0C, 1'b0, 32'd0, 4'hF, rd, ak, er, tq);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL rst_status: got %h want 0", rd);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] ra, rb, rd; logic ak, er; time ta, tb;
    longint n;
    do_reset();
    bus(32'h10, 1'b0, 32'd0, 4'hF, ra, ak, er, ta);
    checks++;
    if (ra !== 32'd0 || ak !== 1'b1) begin
      errors++;
      $display("FAIL cycles_after_reset: got %h ack=%b want 0 ack=1", ra, ak);
    end
    repeat (7) @(posedge wb_clk_i);
    #1;
    bus(32'h10, 1'b0, 32'd0, 4'hF, rb, ak, er, tb);
    n = (tb - ta) / 10;
`ifdef FW_INTERFACE_CYCLE_COUNTER_EN
    checks++;
    if (rb - ra !== n[31:0]) begin
      errors++;
      $display("FAIL cycles_delta: got %0d want %0d", rb - ra, n);
    end
`else
    checks++;
    if (rb !== 32'd0) begin
      errors++;
      $display("FAIL cycles_disabled: got %h want 0 (after %0d cycles)", rb, n);
    end
`endif
    do_reset();
    bus(32'h10, 1'b0, 32'd0, 4'hF, rd, ak, er, ta);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL cycles_restart: got %h want 0", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp, irq; logic ak, er, w; logic [3:0] s; time tq;
    logic [2:0] off;
    for (int it = 0; it < 60; it++) begin
      a = $urandom; off = 3'($urandom_range(0, 7)); a[4:2] = off;
      d = $urandom; s = 4'($urandom_range(0, 15)); w = 1'($urandom_range(0, 1));
      irq = $urandom;
      interrupts = irq;
      @(posedge wb_clk_i);
      #1;
      bus(a, w, d, s, rd, ak, er, tq);
      case (off)
        3'd0: exp = m_trig;
        3'd1: exp = m_scr;
        3'd2: exp = irq;
        3'd3: exp = {30'd0, m_stat};
`ifdef FW_INTERFACE_CYCLE_COUNTER_EN
        3'd4: exp = 32'((tq - t_rst) / 10 - 1);
`else
        3'd4: exp = 32'd0;
`endif
        3'd5: exp = 32'h4657_4946;
        default: exp = 32'd0;
      endcase
      checks++;
      if (ak !== (off < 3'd6) || er !== (off >= 3'd6) || rd !== exp) begin
        errors++;
        $display("FAIL random_%0d off=%0d we=%b: ack=%b err=%b dat=%h want dat=%h",
                 it, off, w, ak, er, rd, exp);
      end
      if (w) begin
        case (off)
          3'd0: m_trig = merge(m_trig, d, s);
          3'd1: m_scr = merge(m_scr, d, s);
          3'd3: if (s[0]) m_stat = d[1:0];
          default: ;
        endcase
      end
      checks++;
      if (trigger_reg !== m_trig) begin
        errors++;
        $display("FAIL random_trig_%0d: trig=%h want %h", it, trigger_reg, m_trig);
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_back_to_back();
    test_irq();
    test_unmapped_status();
    test_cancel();
    test_reset_mid_access();
    test_cycles();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
